mux3_arbiter: RTL and testbench
===============================

// Module: mux3_arbiter
// PURPOSE
//  Shares one WIDTH-bit output register among three requesters (ports 0..2).
//  Generates the 2-bit select for the 3:1 8-bit data mux and registers the winning word.
//  Presents that word downstream on a valid/ready handshake.
//  Arbitration is round-robin with a bounded burst per owner.
//  Sits between the three operand sources and the shared consumer.
// PARAMETERS
//  WIDTH      8  data width of d0/d1/d2/y
//  BURST_LEN  4  max consecutive captures by one owner while others wait (>=1; 1 = pure round-robin)
// PORTS
//  clk      in   1      rising-edge clock, the only clock
//  rst_n    in   1      synchronous active-low reset
//  req      in   3      req[i]=1: d<i> holds a valid word
//  d0       in   WIDTH  requester 0 data
//  d1       in   WIDTH  requester 1 data
//  d2       in   WIDTH  requester 2 data
//  ack      out  3      one-hot, combinational; ack[i]=1 in the cycle d<i> is captured
//  sel      out  2      mux select: 00=d0, 01=d1, 10=d2; 11 never driven
//  y        out  WIDTH  registered output word
//  y_src    out  2      index of the requester that supplied y
//  y_valid  out  1      y holds an untaken word
//  y_ready  in   1      consumer accepts y when y_valid && y_ready
// BEHAVIOUR
//  Reset, sync, rst_n low at posedge:
//   - y=0, y_src=0, y_valid=0, owner=2, burst_cnt=0.
//   - ack is forced 0 while rst_n is low.
//   - A word held mid-transfer is discarded; the first grant after reset goes to req0.
//  cap = (|req) && (!y_valid || y_ready) && rst_n. One capture per cycle at most.
//  Full throughput: back-to-back captures when y_ready stays 1.
//  Winner selection, combinational:
//   - If req[owner] && burst_cnt < BURST_LEN-1, the winner is owner.
//   - Otherwise, search order is owner+1, owner+2, owner (mod 3); the first set req wins.
//  sel = winner when |req; otherwise sel holds owner.
//  On cap at posedge:
//   - y <= d[winner], y_src <= winner, y_valid <= 1.
//   - ack[winner]=1 during that cycle.
//   - If winner==owner, burst_cnt <= burst_cnt+1; else owner <= winner and burst_cnt <= 0.
//   - If burst_cnt has reached BURST_LEN-1 and the owner is the only requester, the owner wins again and burst_cnt <= 0.
//  No cap, y_valid && y_ready: y_valid <= 0.
//  No cap, !y_ready (stall): y, y_src, y_valid hold; ack=0; owner and burst_cnt hold.
//  Requester rule: hold req[i] and d<i> stable until ack[i]. Drop or update req/data in the cycle after ack.
//  Simultaneous take and refill (y_valid && y_ready && |req) capture a new word the same cycle, with no bubble.
//  States:
//   - EMPTY (y_valid=0): to FULL on cap.
//   - FULL (y_valid=1): stays FULL on cap or stall; to EMPTY on y_ready && !cap.
//  burst_cnt is clog2(BURST_LEN)-wide, min 1 bit. It never exceeds BURST_LEN-1 and never wraps.
// CONFIGURATION
//  MUX3_ARB_FIXED_PRIO_EN:
//   - Defined: fixed priority, req0 > req1 > req2.
//   - The winner is the lowest set index; BURST_LEN and burst_cnt are ignored, with burst_cnt held at 0.
//   - owner is still updated on cap.
//  Not defined: round-robin with burst as described above.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles with req=111 -> ack=000, y_valid=0, y=0. After release with req=111 and y_ready=1, the first ack is 001 and sel=00.
//  2. Burst, BURST_LEN=4: req=011, y_ready=1, d0=A5, d1=3C -> acks 001,001,001,001,010,010,010,010,001; y_src follows one cycle later.
//  3. Stall: y_valid=1, y=A5, y_ready=0 for 5 cycles with req=111 -> y=A5 held, ack=000. When y_ready=1, a new word is captured the same cycle with no bubble.
//  4. Lone owner: req=100, BURST_LEN=2, y_ready=1 -> ack=100 every cycle, sel=10; sel is never 11.
//  5. Reset mid-transfer: y_valid=1, y=3C, rst_n=0 for one cycle -> y_valid=0 next cycle and the owner restarts so req0 wins first.
//  6. With MUX3_ARB_FIXED_PRIO_EN: req=110 then 111 -> ack=010 repeatedly, then 001 repeatedly; req2 is starved by design.

Source files
------------

// File: rtl/mux3_arb_if.sv
// Bus bundle between the three requesters / consumer and mux3_arbiter.
// master: requesters and consumer side; slave: the arbiter.
interface mux3_arb_if #(
    parameter int unsigned WIDTH = 8
);
    logic [2:0]       req;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [2:0]       ack;
    logic [1:0]       sel;
    logic [WIDTH-1:0] y;
    logic [1:0]       y_src;
    logic             y_valid;
    logic             y_ready;

    modport master (
        output req, d0, d1, d2, y_ready,
        input  ack, sel, y, y_src, y_valid
    );

    modport slave (
        input  req, d0, d1, d2, y_ready,
        output ack, sel, y, y_src, y_valid
    );
endinterface

// File: rtl/mux3_arbiter.sv
// Three-way arbiter feeding one registered output word on a valid/ready handshake.
// Round-robin with bounded bursts per owner by default; defining
// MUX3_ARB_FIXED_PRIO_EN switches to fixed priority req0 > req1 > req2.
module mux3_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    mux3_arb_if.slave bus
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       y_src_q, y_src_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       win;
    logic [WIDTH-1:0] win_data;
    logic             any_req;
    logic             cap;

`ifndef MUX3_ARB_FIXED_PRIO_EN
    localparam int unsigned CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_LEN - 1);

    // own_vld_q is clear after reset so the first grant searches from req0
    // instead of letting the reset owner keep the bus.
    logic [CW-1:0] cnt_q, cnt_d;
    logic          own_vld_q, own_vld_d;
    logic [1:0]    nxt1, nxt2;
`endif

    assign any_req = |bus.req;
    assign cap     = any_req && ((state_q == EMPTY) || bus.y_ready) && rst_n;

    // Winner selection; falls back to the owner when nothing else applies.
    always_comb begin
        win = owner_q;
`ifdef MUX3_ARB_FIXED_PRIO_EN
        if (bus.req[0])      win = 2'd0;
        else if (bus.req[1]) win = 2'd1;
        else if (bus.req[2]) win = 2'd2;
`else
        nxt1 = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
        nxt2 = (nxt1 == 2'd2) ? 2'd0 : nxt1 + 2'd1;
        if (own_vld_q && bus.req[owner_q] && (cnt_q < CNT_MAX)) win = owner_q;
        else if (bus.req[nxt1])                                 win = nxt1;
        else if (bus.req[nxt2])                                 win = nxt2;
        else                                                    win = owner_q;
`endif
    end

    // 3:1 data mux driven by the winner.
    always_comb begin
        case (win)
            2'd0:    win_data = bus.d0;
            2'd1:    win_data = bus.d1;
            default: win_data = bus.d2;
        endcase
    end

    assign bus.ack     = cap ? (3'b001 << win) : 3'b000;
    assign bus.sel     = win;
    assign bus.y       = y_q;
    assign bus.y_src   = y_src_q;
    assign bus.y_valid = (state_q == FULL);

    // Next-state: output buffer occupancy, captured word and ownership.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        y_src_d = y_src_q;
        owner_d = owner_q;
`ifndef MUX3_ARB_FIXED_PRIO_EN
        cnt_d     = cnt_q;
        own_vld_d = own_vld_q;
`endif
        case (state_q)
            EMPTY:   if (cap) state_d = FULL;
            default: if (bus.y_ready && !cap) state_d = EMPTY;
        endcase
        if (cap) begin
            y_d     = win_data;
            y_src_d = win;
            owner_d = win;
`ifndef MUX3_ARB_FIXED_PRIO_EN
            own_vld_d = 1'b1;
            if (own_vld_q && (win == owner_q))
                cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
            else
                cnt_d = '0;
`endif
        end
    end

    // Buffer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Datapath and arbitration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q     <= '0;
            y_src_q <= 2'd0;
            owner_q <= 2'd2;
`ifndef MUX3_ARB_FIXED_PRIO_EN
            cnt_q     <= '0;
            own_vld_q <= 1'b0;
`endif
        end else begin
            y_q     <= y_d;
            y_src_q <= y_src_d;
            owner_q <= owner_d;
`ifndef MUX3_ARB_FIXED_PRIO_EN
            cnt_q     <= cnt_d;
            own_vld_q <= own_vld_d;
`endif
        end
    end
endmodule

// File: tb/tb_mux3_arbiter.sv
// Testbench for mux3_arbiter: directed steps then random traffic against a run-length model.
module tb_mux3_arbiter;
    localparam int unsigned WIDTH     = 8;
    localparam int unsigned BURST_LEN = 4;

    logic clk;
    logic rst_n;
    mux3_arb_if #(.WIDTH(WIDTH)) bus();

    mux3_arbiter #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Reference model: owner, length of its current run of captures, output buffer.
    int         m_owner;
    int         m_run;
    bit         m_has;
    logic [7:0] m_y;
    int         m_src;
    bit         m_valid;

    logic [2:0] obs_ack;
    logic [1:0] obs_sel;
    logic [7:0] obs_y;

    logic [2:0] exp2 [9];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r);
`ifdef MUX3_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 3; k++) if (r[k]) return k;
        return m_owner;
`else
        if (m_has && r[m_owner] && (m_run < int'(BURST_LEN))) return m_owner;
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_owner + k) % 3;
            if (r[c]) return c;
        end
        return m_owner;
`endif
    endfunction

    task automatic model_reset();
        m_owner = 2; m_run = 0; m_has = 0;
        m_y = 8'h00; m_src = 0; m_valid = 0;
    endtask

    // One clock: check outputs at negedge, advance model at posedge.
    task automatic cyc();
        logic [2:0] r;
        logic [7:0] dw;
        int         w;
        bit         cap;
        bit         rs;
        bit         ry;
        @(negedge clk);
        r   = bus.req;
        rs  = rst_n;
        ry  = bus.y_ready;
        w   = pick(r);
        cap = (|r) && (!m_valid || ry) && rs;
        dw  = (w == 0) ? bus.d0 : (w == 1) ? bus.d1 : bus.d2;
        obs_ack = bus.ack;
        obs_sel = bus.sel;
        obs_y   = bus.y;
        chk("ack",     32'(bus.ack),     cap ? (32'd1 << w) : 32'd0);
        chk("sel",     32'(bus.sel),     32'(w));
        chk("y",       32'(bus.y),       32'(m_y));
        chk("y_src",   32'(bus.y_src),   32'(m_src));
        chk("y_valid", 32'(bus.y_valid), 32'(m_valid));
        @(posedge clk);
        if (!rs) begin
            model_reset();
        end else if (cap) begin
            m_y = dw; m_src = w; m_valid = 1;
            if (m_has && (w == m_owner)) m_run = (m_run == int'(BURST_LEN)) ? 1 : m_run + 1;
            else                         m_run = 1;
            m_owner = w;
            m_has   = 1;
        end else if (m_valid && ry) begin
            m_valid = 0;
        end
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        exp2 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b001};

        // Reset with all requesting: initialise DUT and model on the first edge.
        rst_n = 1'b0;
        bus.req = 3'b111; bus.d0 = 8'h11; bus.d1 = 8'h22; bus.d2 = 8'h33;
        bus.y_ready = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        cyc();
        chk("t1_rst_ack", 32'(obs_ack), 32'd0);
        chk("t1_rst_y", 32'(obs_y), 32'd0);
        rst_n = 1'b1; bus.y_ready = 1'b1;
        cyc();
        chk("t1_first_ack", 32'(obs_ack), 32'b001);
        chk("t1_first_sel", 32'(obs_sel), 32'd0);

        // Burst behaviour with two requesters.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus.req = 3'b011; bus.d0 = 8'hA5; bus.d1 = 8'h3C;
        for (int i = 0; i < 9; i++) begin
            cyc();
`ifdef MUX3_ARB_FIXED_PRIO_EN
            chk("t2_ack", 32'(obs_ack), 32'b001);
`else
            chk("t2_ack", 32'(obs_ack), 32'(exp2[i]));
`endif
        end

        // Stall holds the word; release refills with no bubble.
        bus.y_ready = 1'b0; bus.req = 3'b111;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_hold_y", 32'(obs_y), 32'hA5);
            chk("t3_hold_ack", 32'(obs_ack), 32'd0);
        end
        bus.y_ready = 1'b1;
        cyc();
        chk("t3_refill", 32'(obs_ack != 3'b000), 32'd1);
        chk("t3_valid", 32'(bus.y_valid), 32'd1);

        // Lone requester 2 keeps winning across the burst limit.
        bus.req = 3'b100; bus.d2 = 8'h3C;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("t4_ack", 32'(obs_ack), 32'b100);
            chk("t4_sel", 32'(obs_sel), 32'd2);
        end

        // Reset while a word is held.
        chk("t5_pre_y", 32'(bus.y), 32'h3C);
        rst_n = 1'b0;
        cyc();
        chk("t5_valid", 32'(bus.y_valid), 32'd0);
        rst_n = 1'b1; bus.req = 3'b111;
        cyc();
        chk("t5_first_ack", 32'(obs_ack), 32'b001);

`ifdef MUX3_ARB_FIXED_PRIO_EN
        // Fixed priority starves req2.
        bus.req = 3'b110;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_ack_110", 32'(obs_ack), 32'b010);
        end
        bus.req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_ack_111", 32'(obs_ack), 32'b001);
        end
`endif

        // Random traffic: requesters change only after their ack.
        for (int n = 0; n < 500; n++) begin
            bus.y_ready = ($urandom_range(99) < 70);
            rst_n = ($urandom_range(99) != 0);
            for (int i = 0; i < 3; i++) begin
                if (obs_ack[i] || !bus.req[i]) begin
                    bus.req[i] = ($urandom_range(99) < 55);
                    case (i)
                        0:       bus.d0 = 8'($urandom);
                        1:       bus.d1 = 8'($urandom);
                        default: bus.d2 = 8'($urandom);
                    endcase
                end
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
